// File: rtl/task_scheduler.sv
// task_scheduler: feeds 16-instruction programs to an array of gpu cores.
//   Host side : prog_we_i/prog_addr_i/prog_wdata_i write the instruction store;
//               task_valid_i/task_base_i/task_ready_o push task descriptors into a FIFO.
//   Core side : instruction_o is a shared bus, val_ins_o strobes one core at a time,
//               core_rtr_i gates dispatch, core_ready_i (level) reports completion.
//   Status    : task_done_o/task_done_core_o pulse per completion, done_count_o counts them,
//               busy_o is high while tasks are queued or any core is loading/running.
// Build option: define SCHED_RR_EN for round-robin dispatch; otherwise the lowest-index
// eligible core wins.
module task_scheduler #(
  parameter int unsigned NUM_CORES   = 4,
  parameter int unsigned PROG_DEPTH  = 256,
  parameter int unsigned QUEUE_DEPTH = 8,
  localparam int unsigned AW = $clog2(PROG_DEPTH),
  localparam int unsigned QW = $clog2(QUEUE_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 prog_we_i,
  input  logic [AW-1:0]        prog_addr_i,
  input  logic [15:0]          prog_wdata_i,
  input  logic                 task_valid_i,
  input  logic [AW-1:0]        task_base_i,
  output logic                 task_ready_o,
  output logic [15:0]          instruction_o,
  output logic [NUM_CORES-1:0] val_ins_o,
  input  logic [NUM_CORES-1:0] core_rtr_i,
  input  logic [NUM_CORES-1:0] core_ready_i,
  output logic                 task_done_o,
  output logic [2:0]           task_done_core_o,
  output logic                 busy_o,
  output logic [15:0]          done_count_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StStream} state_e;
  typedef enum logic [1:0] {SlotFree, SlotLoad, SlotRun} slot_e;

  // Instruction store (not reset) with a registered read port.
  logic [15:0]   mem_q [PROG_DEPTH];
  logic [15:0]   rd_data_q;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  always_ff @(posedge clk_i) begin
    if (prog_we_i) mem_q[prog_addr_i] <= prog_wdata_i;
  end

  // Only reads for the active stream update the bus, so it holds its last word otherwise.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)  rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  // Task FIFO.
  logic [AW-1:0] fifo_q [QUEUE_DEPTH];
  logic [QW-1:0] wr_ptr_q, rd_ptr_q;
  logic [QW:0]   cnt_q;
  logic          full, empty, push, pop;

  assign full  = (cnt_q == (QW+1)'(QUEUE_DEPTH));
  assign empty = (cnt_q == '0);
  assign push  = task_valid_i && !full;

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= task_base_i;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Core slots and dispatch selection.
  slot_e                slot_q [NUM_CORES];
  slot_e                slot_d [NUM_CORES];
  logic [NUM_CORES-1:0] elig;
  logic [2:0]           sel, cmp_idx;
  logic                 sel_vld, cmp_vld;

  // Slot state is registered, so a core completing this cycle is not yet eligible.
  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) elig[c] = (slot_q[c] == SlotFree) && core_rtr_i[c];
  end

`ifdef SCHED_RR_EN
  logic [2:0] rr_q;

  // Pick the eligible core at the smallest rotational distance from rr_q.
  always_comb begin
    int unsigned d, best;
    sel     = '0;
    sel_vld = 1'b0;
    best    = NUM_CORES;
    for (int c = 0; c < NUM_CORES; c++) begin
      d = (c + NUM_CORES - int'(rr_q)) % NUM_CORES;
      if (elig[c] && d < best) begin
        best    = d;
        sel     = 3'(c);
        sel_vld = 1'b1;
      end
    end
  end
`else
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int c = NUM_CORES - 1; c >= 0; c--) begin
      if (elig[c]) begin
        sel     = 3'(c);
        sel_vld = 1'b1;
      end
    end
  end
`endif

  // Lowest-index completion wins; others stay in RUN and are taken on later cycles.
  always_comb begin
    cmp_vld = 1'b0;
    cmp_idx = '0;
    for (int c = NUM_CORES - 1; c >= 0; c--) begin
      if (slot_q[c] == SlotRun && core_ready_i[c]) begin
        cmp_vld = 1'b1;
        cmp_idx = 3'(c);
      end
    end
  end

  // Load FSM.
  state_e        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [2:0]    tgt_q, tgt_d;
  logic [3:0]    k_q, k_d;
  logic          dispatch, load_end;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      base_q  <= '0;
      tgt_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      tgt_q   <= tgt_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    tgt_d    = tgt_q;
    k_d      = k_q;
    dispatch = 1'b0;
    load_end = 1'b0;
    case (state_q)
      StIdle: begin
        if (!empty && sel_vld) begin
          state_d  = StIssue;
          base_d   = fifo_q[rd_ptr_q];
          tgt_d    = sel;
          k_d      = '0;
          dispatch = 1'b1;
        end
      end
      StIssue: state_d = StStream;
      StStream: begin
        k_d = k_q + 4'd1;
        if (k_q == 4'd15) begin
          state_d  = StIdle;
          load_end = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign pop = dispatch;

  // Word k is on the bus while word k+1 is being read; the address wraps in AW bits.
  always_comb begin
    rd_en     = 1'b0;
    rd_addr   = base_q;
    val_ins_o = '0;
    case (state_q)
      StIssue: rd_en = 1'b1;
      StStream: begin
        rd_en   = (k_q != 4'd15);
        rd_addr = base_q + AW'(k_q) + AW'(1);
        for (int c = 0; c < NUM_CORES; c++) val_ins_o[c] = (tgt_q == 3'(c));
      end
      default: ;
    endcase
  end

`ifdef SCHED_RR_EN
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)     rr_q <= '0;
    else if (dispatch) rr_q <= (sel == 3'(NUM_CORES - 1)) ? 3'd0 : sel + 3'd1;
  end
`endif

  // Slot updates and completion reporting.
  logic        task_done_q;
  logic [2:0]  done_core_q;
  logic [15:0] done_cnt_q;

  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) begin
      slot_d[c] = slot_q[c];
      if (cmp_vld && cmp_idx == 3'(c))  slot_d[c] = SlotFree;
      if (dispatch && sel == 3'(c))     slot_d[c] = SlotLoad;
      if (load_end && tgt_q == 3'(c))   slot_d[c] = SlotRun;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int c = 0; c < NUM_CORES; c++) slot_q[c] <= SlotFree;
      task_done_q <= 1'b0;
      done_core_q <= '0;
      done_cnt_q  <= '0;
    end else begin
      for (int c = 0; c < NUM_CORES; c++) slot_q[c] <= slot_d[c];
      task_done_q <= cmp_vld;
      if (cmp_vld) begin
        done_core_q <= cmp_idx;
        done_cnt_q  <= done_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    busy_o = !empty;
    for (int c = 0; c < NUM_CORES; c++) begin
      if (slot_q[c] != SlotFree) busy_o = 1'b1;
    end
  end

  assign task_ready_o     = !full;
  assign instruction_o    = rd_data_q;
  assign task_done_o      = task_done_q;
  assign task_done_core_o = done_core_q;
  assign done_count_o     = done_cnt_q;

endmodule

// File: tb/tb_task_scheduler.sv
module tb_task_scheduler;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          prog_we;
  logic [7:0]    prog_addr;
  logic [15:0]   prog_wdata;
  logic          task_valid;
  logic [7:0]    task_base;
  logic          task_ready;
  logic [15:0]   instruction;
  logic [NC-1:0] val_ins;
  logic [NC-1:0] core_rtr;
  logic [NC-1:0] core_ready;
  logic          task_done;
  logic [2:0]    task_done_core;
  logic          busy;
  logic [15:0]   done_count;

  task_scheduler #(.NUM_CORES(NC), .PROG_DEPTH(256), .QUEUE_DEPTH(8)) dut (
    .clk_i           (clk),
    .reset_ni        (reset_n),
    .prog_we_i       (prog_we),
    .prog_addr_i     (prog_addr),
    .prog_wdata_i    (prog_wdata),
    .task_valid_i    (task_valid),
    .task_base_i     (task_base),
    .task_ready_o    (task_ready),
    .instruction_o   (instruction),
    .val_ins_o       (val_ins),
    .core_rtr_i      (core_rtr),
    .core_ready_i    (core_ready),
    .task_done_o     (task_done),
    .task_done_core_o(task_done_core),
    .busy_o          (busy),
    .done_count_o    (done_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    logic [2:0]  core;
  } exp_t;

  exp_t        sb_q[$];
  logic [2:0]  done_q[$];
  logic [15:0] model_mem [256];
  int          errors = 0;
  int          checks = 0;
  int          exp_done = 0;

  // Stream and completion monitor, sampled on the falling edge.
  exp_t        mon_e;
  logic [2:0]  mon_c;
  logic [NC-1:0] mon_v;
  always @(negedge clk) begin
    if (reset_n === 1'b1 && val_ins !== '0) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL stream_unexpected: val_ins=%b instr=%h, expected no stream", val_ins,
                 instruction);
      end else begin
        mon_e = sb_q.pop_front();
        mon_v = NC'(1) << mon_e.core;
        if (val_ins !== mon_v || instruction !== mon_e.word) begin
          errors++;
          $display("FAIL stream: val_ins=%b instr=%h, expected val_ins=%b instr=%h", val_ins,
                   instruction, mon_v, mon_e.word);
        end
      end
    end
    if (reset_n === 1'b1 && task_done === 1'b1) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: core=%0d, expected no completion", task_done_core);
      end else begin
        mon_c = done_q.pop_front();
        if (task_done_core !== mon_c) begin
          errors++;
          $display("FAIL done_core: got %0d expected %0d", task_done_core, mon_c);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog_write(input int a, input logic [15:0] d);
    prog_we    = 1'b1;
    prog_addr  = 8'(a);
    prog_wdata = d;
    model_mem[a] = d;
    tick();
    prog_we = 1'b0;
  endtask

  // Offers one task; expected words go to the scoreboard on the accepting edge.
  task automatic push_task(input logic [7:0] base, input logic [2:0] core);
    exp_t e;
    bit   ok = 1'b0;
    task_valid = 1'b1;
    task_base  = base;
    for (int t = 0; t < 300 && !ok; t++) begin
      if (task_ready) begin
        for (int i = 0; i < 16; i++) begin
          e.word = model_mem[(int'(base) + i) % 256];
          e.core = core;
          sb_q.push_back(e);
        end
        ok = 1'b1;
      end
      tick();
    end
    task_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_timeout: task_ready stayed 0, expected accept of base %h", base);
    end
  endtask

  task automatic wait_drain(input int bound);
    bit ok = 1'b0;
    for (int t = 0; t < bound && !ok; t++) begin
      if (sb_q.size() == 0 && val_ins === '0) ok = 1'b1;
      else tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_timeout: %0d words pending, expected 0", sb_q.size());
    end
  endtask

  task automatic wait_val(input logic want);
    bit ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      if ((val_ins[0] === 1'b1) == want) ok = 1'b1;
      else tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL val_wait: val_ins[0] never became %b", want);
    end
  endtask

  task automatic check_count(input string name);
    checks++;
    if (done_count !== 16'(exp_done)) begin
      errors++;
      $display("FAIL %s: done_count=%0d expected %0d", name, done_count, exp_done);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({task_ready, val_ins, busy, task_done, task_done_core, done_count, instruction} !==
        {1'b1, NC'(0), 1'b0, 1'b0, 3'd0, 16'd0, 16'd0}) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b val=%b busy=%b done=%b core=%0d cnt=%0d ins=%h, expected rdy=1 rest 0",
               task_ready, val_ins, busy, task_done, task_done_core, done_count, instruction);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int n = 0;
    core_rtr = 4'b0001;
    push_task(8'h00, 3'd0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
    tick();
    checks++;
    if (val_ins !== 4'b0000) begin
      errors++; $display("FAIL basic_latency1: val_ins=%b expected 0000", val_ins);
    end
    tick();
    for (int i = 0; i < 16; i++) begin
      if (val_ins === 4'b0001) n++;
      tick();
    end
    checks++;
    if (n != 16 || val_ins !== 4'b0000) begin
      errors++;
      $display("FAIL basic_contig: %0d high cycles then val_ins=%b, expected 16 then 0000", n,
               val_ins);
    end
    checks++;
    if (instruction !== 16'h100F) begin
      errors++; $display("FAIL basic_hold: instr=%h expected 100f", instruction);
    end
    done_q.push_back(3'd0);
    core_ready = 4'b0001;
    tick();
    core_ready = 4'b0000;
    exp_done++;
    tick();
    check_count("basic_count");
  endtask

  task automatic test_wrap();
    core_rtr = 4'b0001;
    push_task(8'hFC, 3'd0);
    wait_drain(100);
    done_q.push_back(3'd0);
    core_ready = 4'b0001;
    tick();
    core_ready = 4'b0000;
    exp_done++;
    tick();
    check_count("wrap_count");
  endtask

  task automatic test_fifo_full();
    core_rtr = 4'b0000;
    for (int i = 0; i < 8; i++) push_task(8'(16 * i), 3'd0);
    checks++;
    if (task_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready: got %b expected 0", task_ready);
    end
    task_valid = 1'b1;
    task_base  = 8'h80;
    repeat (3) tick();
    checks++;
    if (task_ready !== 1'b0 || val_ins !== 4'b0000) begin
      errors++;
      $display("FAIL full_hold: ready=%b val_ins=%b expected 0 and 0000", task_ready, val_ins);
    end
    core_rtr = 4'b0001;
    #1;
    checks++;
    if (task_ready !== 1'b0) begin
      errors++; $display("FAIL full_pop_cycle: ready=%b expected 0", task_ready);
    end
    tick();
    checks++;
    if (task_ready !== 1'b1) begin
      errors++; $display("FAIL full_after_pop: ready=%b expected 1", task_ready);
    end
    push_task(8'h80, 3'd0);
    for (int i = 0; i < 9; i++) begin
      wait_val(1'b1);
      wait_val(1'b0);
      done_q.push_back(3'd0);
      core_ready = 4'b0001;
      tick();
      core_ready = 4'b0000;
      exp_done++;
    end
    tick();
    check_count("full_count");
  endtask

  task automatic test_simultaneous_done();
    core_rtr = 4'b0010;
    push_task(8'h30, 3'd1);
    wait_drain(100);
    core_rtr = 4'b1000;
    push_task(8'h40, 3'd3);
    wait_drain(100);
    core_rtr = 4'b0000;
    done_q.push_back(3'd1);
    done_q.push_back(3'd3);
    core_ready = 4'b1010;
    tick();
    checks++;
    if (task_done !== 1'b1 || task_done_core !== 3'd1) begin
      errors++; $display("FAIL simul_first: done=%b core=%0d expected 1/1", task_done, task_done_core);
    end
    tick();
    checks++;
    if (task_done !== 1'b1 || task_done_core !== 3'd3) begin
      errors++; $display("FAIL simul_second: done=%b core=%0d expected 1/3", task_done, task_done_core);
    end
    core_ready = 4'b0000;
    tick();
    checks++;
    if (task_done !== 1'b0) begin
      errors++; $display("FAIL simul_third: done=%b expected 0", task_done);
    end
    exp_done += 2;
    check_count("simul_count");
  endtask

  task automatic test_dispatch_order();
    logic [2:0] order [8];
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    exp_done = 0;
    check_count("order_reset_count");
    for (int i = 0; i < 8; i++) begin
`ifdef SCHED_RR_EN
      order[i] = 3'(i % 4);
`else
      // Core 0 is still in RUN at the next decision, so core 1 takes every other task.
      order[i] = 3'(i % 2);
`endif
    end
    core_rtr   = 4'b1111;
    core_ready = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      push_task(8'(16 * i), order[i]);
      done_q.push_back(order[i]);
    end
    wait_drain(400);
    repeat (3) tick();
    core_ready = 4'b0000;
    exp_done = 8;
    check_count("order_count");
  endtask

  task automatic test_reset_midload();
    core_rtr   = 4'b0001;
    core_ready = 4'b0000;
    push_task(8'h20, 3'd0);
    wait_val(1'b1);
    repeat (6) tick();
    checks++;
    if (val_ins !== 4'b0001 || instruction !== model_mem[8'h26]) begin
      errors++;
      $display("FAIL midload_seventh: val_ins=%b instr=%h expected 0001/%h", val_ins, instruction,
               model_mem[8'h26]);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (val_ins !== 4'b0000 || task_ready !== 1'b1 || done_count !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midload_reset: val=%b rdy=%b cnt=%0d busy=%b expected 0000/1/0/0", val_ins,
               task_ready, done_count, busy);
    end
    sb_q.delete();
    tick();
    reset_n  = 1'b1;
    exp_done = 0;
    push_task(8'h00, 3'd0);
    wait_drain(100);
    done_q.push_back(3'd0);
    core_ready = 4'b0001;
    tick();
    core_ready = 4'b0000;
    exp_done++;
    tick();
    check_count("midload_count");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    prog_we    = 1'b0;
    prog_addr  = '0;
    prog_wdata = '0;
    task_valid = 1'b0;
    task_base  = '0;
    core_rtr   = '0;
    core_ready = '0;
    test_reset();
    for (int i = 0; i < 256; i++) prog_write(i, 16'(16'h1000 + i));
    test_basic();
    test_wrap();
    test_fifo_full();
    test_simultaneous_done();
    test_dispatch_order();
    test_reset_midload();
    repeat (3) tick();
    checks++;
    if (sb_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL leftovers: %0d words and %0d completions pending, expected 0", sb_q.size(),
               done_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
